// File: rtl/nrisc_ula_pkg.sv
// nrisc_ula_pkg
//   Shared definitions for the NRISC_ULA and its issue-side sequencer:
//   opcode encodings, {N,Z,C} flag bit positions, sequencer states and an
//   opcode classifier (single-step / multi-step / undefined).
package nrisc_ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_RTR = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_RTL = 4'b1110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    OPC_SINGLE = 2'd0,
    OPC_MULTI  = 2'd1,
    OPC_UNDEF  = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: return OPC_SINGLE;
      OP_SHR, OP_RTR, OP_SHL, OP_RTL:                return OPC_MULTI;
      default:                                       return OPC_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// ula_sequencer_if
//   Request and response valid/ready channels of the ULA sequencer.
//   master : requester/consumer (drives req_*, rsp_ready)
//   slave  : sequencer (drives req_ready, rsp_*)
interface ula_sequencer_if #(
  parameter int unsigned TAM   = 16,
  parameter int unsigned CNT_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [TAM-1:0]   req_a;
  logic [TAM-1:0]   req_b;
  logic [CNT_W-1:0] req_cnt;
  logic             req_incdec;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAM-1:0]   rsp_data;
  logic [2:0]       rsp_flags;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cnt, req_incdec, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cnt, req_incdec, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

endinterface

// File: rtl/NRISC_ULA.sv
// NRISC_ULA
//   Combinational ALU.
//   ULA_A, ULA_B : operands
//   ULA_ctrl     : opcode (see nrisc_ula_pkg)
//   incdec       : ADD adds one more, SUB subtracts one more
//   ULA_OUT      : result
//   ULA_flags    : {N,Z,C}. N is the result sign for ADD/SUB only; Z is
//                  result==0; C is carry-out (ADD), borrow (SUB), or the bit
//                  shifted/rotated out (single-bit shifts/rotates).
//                  SHR is an arithmetic shift (sign bit replicated).
module NRISC_ULA
  import nrisc_ula_pkg::*;
#(
  parameter int unsigned TAM = 16
) (
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  input  logic           incdec,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);

  logic [TAM:0] sum;
  logic         neg;
  logic         cry;

  always_comb begin
    sum     = '0;
    neg     = 1'b0;
    cry     = 1'b0;
    ULA_OUT = '0;
    case (ULA_ctrl)
      OP_ADD: begin
        sum     = {1'b0, ULA_A} + {1'b0, ULA_B} + {{TAM{1'b0}}, incdec};
        ULA_OUT = sum[TAM-1:0];
        cry     = sum[TAM];
        neg     = sum[TAM-1];
      end
      OP_SUB: begin
        // Bit TAM of the extended difference is the borrow.
        sum     = {1'b0, ULA_A} - {1'b0, ULA_B} - {{TAM{1'b0}}, incdec};
        ULA_OUT = sum[TAM-1:0];
        cry     = sum[TAM];
        neg     = sum[TAM-1];
      end
      OP_AND: ULA_OUT = ULA_A & ULA_B;
      OP_OR:  ULA_OUT = ULA_A | ULA_B;
      OP_XOR: ULA_OUT = ULA_A ^ ULA_B;
      OP_NOT: ULA_OUT = ~ULA_A;
      OP_SHR: begin
        ULA_OUT = {ULA_A[TAM-1], ULA_A[TAM-1:1]};
        cry     = ULA_A[0];
      end
      OP_RTR: begin
        ULA_OUT = {ULA_A[0], ULA_A[TAM-1:1]};
        cry     = ULA_A[0];
      end
      OP_SHL: begin
        ULA_OUT = {ULA_A[TAM-2:0], 1'b0};
        cry     = ULA_A[TAM-1];
      end
      OP_RTL: begin
        ULA_OUT = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
        cry     = ULA_A[TAM-1];
      end
      default: ULA_OUT = '0;
    endcase
  end

  always_comb begin
    ULA_flags        = '0;
    ULA_flags[FLG_N] = neg;
    ULA_flags[FLG_Z] = (ULA_OUT == '0);
    ULA_flags[FLG_C] = cry;
  end

endmodule

// File: rtl/ula_sequencer.sv
// ula_sequencer
//   Issue-side controller for the combinational NRISC_ULA. Accepts one
//   request, drives registered operands/control onto the ULA, and returns
//   the captured result/flags. Multi-bit shifts/rotates run as repeated
//   single-bit ULA steps with the ULA output fed back as the next ULA_A.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : request/response channels (slave side)
//   ula_a/b    : registered operands to the ULA
//   ula_ctrl   : registered opcode to the ULA (AND when idle/undefined)
//   ula_incdec : registered incdec, ADD/SUB only
//   ula_out    : ULA result
//   ula_flags  : ULA {N,Z,C}
module ula_sequencer
  import nrisc_ula_pkg::*;
#(
  parameter int unsigned TAM   = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  ula_sequencer_if.slave bus,
  output logic [TAM-1:0] ula_a,
  output logic [TAM-1:0] ula_b,
  output logic [3:0]     ula_ctrl,
  output logic           ula_incdec,
  input  logic [TAM-1:0] ula_out,
  input  logic [2:0]     ula_flags
);

  seq_state_e       state_q;
  logic [TAM-1:0]   ula_a_q;
  logic [TAM-1:0]   ula_b_q;
  logic [3:0]       ula_ctrl_q;
  logic             ula_incdec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [TAM-1:0]   rsp_data_q;
  logic [2:0]       rsp_flags_q;
  logic             rsp_err_q;

  op_class_e        req_class;
  logic             req_is_arith;
  logic [2:0]       zero_cnt_flags;

  always_comb begin
    req_class      = op_class(bus.req_op);
    req_is_arith   = (bus.req_op == OP_ADD) || (bus.req_op == OP_SUB);
    zero_cnt_flags = '0;
    zero_cnt_flags[FLG_Z] = (bus.req_a == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ula_a_q      <= '0;
      ula_b_q      <= '0;
      ula_ctrl_q   <= OP_AND;
      ula_incdec_q <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            ula_a_q      <= bus.req_a;
            ula_b_q      <= bus.req_b;
            ula_incdec_q <= req_is_arith ? bus.req_incdec : 1'b0;
            cnt_q        <= bus.req_cnt;
            rsp_err_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            case (req_class)
              OPC_UNDEF: begin
                // Undefined codes never reach the ULA control lines.
                ula_ctrl_q  <= OP_AND;
                rsp_data_q  <= '0;
                rsp_flags_q <= '0;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
              OPC_MULTI: begin
                ula_ctrl_q <= bus.req_op;
                if (bus.req_cnt == '0) begin
                  // Zero-step shift bypasses the ULA: operand returned as-is.
                  rsp_data_q  <= bus.req_a;
                  rsp_flags_q <= zero_cnt_flags;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
                end else begin
                  state_q <= EXEC;
                end
              end
              default: begin
                ula_ctrl_q <= bus.req_op;
                state_q    <= EXEC;
              end
            endcase
          end
        end

        EXEC: begin
          if ((op_class(ula_ctrl_q) == OPC_MULTI) && (cnt_q > CNT_W'(1))) begin
            ula_a_q <= ula_out;
            cnt_q   <= cnt_q - CNT_W'(1);
          end else begin
            rsp_data_q  <= ula_out;
            rsp_flags_q <= ula_flags;
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ula_a         = ula_a_q;
  assign ula_b         = ula_b_q;
  assign ula_ctrl      = ula_ctrl_q;
  assign ula_incdec    = ula_incdec_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer
//   Bench for ula_sequencer with a real NRISC_ULA on the ula_* ports.
//   Directed cases followed by randomized operations, all checked against
//   an arithmetic reference model of the full multi-step operation.
module tb_ula_sequencer;

  localparam int unsigned TAM   = 16;
  localparam int unsigned CNT_W = 4;

  logic           clk;
  logic           rst;
  logic [TAM-1:0] ula_a;
  logic [TAM-1:0] ula_b;
  logic [3:0]     ula_ctrl;
  logic           ula_incdec;
  logic [TAM-1:0] ula_out;
  logic [2:0]     ula_flags;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned cyc;

  ula_sequencer_if #(.TAM(TAM), .CNT_W(CNT_W)) bus ();

  ula_sequencer #(.TAM(TAM), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ula_a      (ula_a),
    .ula_b      (ula_b),
    .ula_ctrl   (ula_ctrl),
    .ula_incdec (ula_incdec),
    .ula_out    (ula_out),
    .ula_flags  (ula_flags)
  );

  NRISC_ULA #(.TAM(TAM)) ula (
    .ULA_A     (ula_a),
    .ULA_B     (ula_b),
    .ULA_ctrl  (ula_ctrl),
    .incdec    (ula_incdec),
    .ULA_OUT   (ula_out),
    .ULA_flags (ula_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Whole-operation reference: result, {N,Z,C}, error, accept->rsp_valid cycles.
  function automatic void model(input int op, input int a, input int b, input int cnt,
                                input int inc, output int data, output int flags,
                                output int err, output int lat);
    int v, n, c, s;
    n = 0; c = 0; err = 0; data = 0; lat = 2;
    case (op)
      0: begin s = a + b + inc; data = s & 'hFFFF; c = (s >> 16) & 1; n = (data >> 15) & 1; end
      1: begin s = a - b - inc; data = s & 'hFFFF; c = (s < 0) ? 1 : 0; n = (data >> 15) & 1; end
      2: data = a & b;
      3: data = a | b;
      4: data = a ^ b;
      7: data = (~a) & 'hFFFF;
      5, 13, 6, 14: begin
        v = a;
        for (int i = 0; i < cnt; i++) begin
          case (op)
            5:  begin c = v & 1; v = (v >> 1) | (v & 'h8000); end
            13: begin c = v & 1; v = (v >> 1) | (c << 15); end
            6:  begin c = (v >> 15) & 1; v = (v << 1) & 'hFFFF; end
            default: begin c = (v >> 15) & 1; v = ((v << 1) & 'hFFFF) | c; end
          endcase
        end
        data = v;
        lat  = cnt + 1;
      end
      default: begin err = 1; lat = 1; end
    endcase
    flags = err ? 0 : ((n << 2) | ((data == 0 ? 1 : 0) << 1) | c);
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] cnt, input logic inc,
                       output int acc, output bit ok);
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_cnt    = cnt;
    bus.req_incdec = inc;
    bus.req_valid  = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        acc = cyc;
        ok  = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) check("req_ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] cnt, input logic inc, input int hold);
    int e_data, e_flags, e_err, e_lat, acc;
    bit ok, got;
    logic [15:0] held;
    model(op, a, b, cnt, inc, e_data, e_flags, e_err, e_lat);
    issue(op, a, b, cnt, inc, acc, ok);
    if (!ok) return;
    check("ula_ctrl", ula_ctrl, e_err ? 32'h2 : 32'(op));
    check("ula_incdec", ula_incdec, (op == 0 || op == 1) ? 32'(inc) : 0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin got = 1'b1; break; end
      check("req_ready_busy", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    if (!got) begin
      check("rsp_valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc - acc, e_lat);
    check("rsp_data", bus.rsp_data, e_data);
    check("rsp_flags", bus.rsp_flags, e_flags);
    check("rsp_err", bus.rsp_err, e_err);
    held = bus.rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_data", bus.rsp_data, held);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"},  bus.rsp_data, 0);
    check({tag, "_rsp_flags"}, bus.rsp_flags, 0);
    check({tag, "_rsp_err"},   bus.rsp_err, 0);
    check({tag, "_ula_a"},     ula_a, 0);
    check({tag, "_ula_b"},     ula_b, 0);
    check({tag, "_ula_ctrl"},  ula_ctrl, 32'h2);
    check({tag, "_ula_incdec"}, ula_incdec, 0);
  endtask

  initial begin
    int acc, spurious;
    bit ok;
    n_cmp = 0;
    n_bad = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cnt    = '0;
    bus.req_incdec = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(4'b0010, 16'h0F0F, 16'hF0F0, 4'd0, 1'b0, 0);   // AND -> 0, Z
    do_op(4'b0101, 16'h8003, 16'h0000, 4'd2, 1'b0, 0);   // SHR x2
    do_op(4'b0110, 16'h4001, 16'h0000, 4'd3, 1'b0, 0);   // SHL x3
    do_op(4'b1110, 16'h1234, 16'h0000, 4'd0, 1'b0, 0);   // RTL x0 bypass
    do_op(4'b1111, 16'hABCD, 16'h1111, 4'd5, 1'b1, 0);   // undefined
    do_op(4'b0000, 16'h0001, 16'h0002, 4'd0, 1'b0, 5);   // ADD, held response
    do_op(4'b0001, 16'h0000, 16'hFFFF, 4'd0, 1'b1, 0);   // SUB borrow with incdec
    do_op(4'b1101, 16'h0001, 16'h0000, 4'd15, 1'b0, 1);  // RTR full count
    do_op(4'b0000, 16'hFFFF, 16'h0001, 4'd9, 1'b1, 0);   // ADD carry + incdec

    // Reset in the middle of a long shift.
    issue(4'b0101, 16'h8000, 16'h0000, 4'd10, 1'b0, acc, ok);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) spurious++;
    end
    bus.rsp_ready = 1'b0;
    check("midrst_no_rsp", spurious, 0);
    do_op(4'b0101, 16'h8003, 16'h0000, 4'd2, 1'b0, 0);

    for (int k = 0; k < 150; k++) begin
      do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
